// File: rtl/bin_to_bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter.
// FSM state encoding, BCD digit width, double-dabble correction constants and
// an elaboration-time helper used to check that DIGITS can hold every input value.
package bin_to_bcd_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StDone  = 2'd2
  } state_e;

  localparam int unsigned BCD_DIGIT_W = 4;

  // A digit at or above this value would exceed 9 after the next shift.
  localparam logic [BCD_DIGIT_W-1:0] ADD3_THRESHOLD = 4'd5;
  localparam logic [BCD_DIGIT_W-1:0] ADD3_VALUE     = 4'd3;

  // 10^n, evaluated only on parameters at elaboration time.
  function automatic longint unsigned pow10(input int unsigned n);
    longint unsigned r;
    r = 64'd1;
    for (int unsigned i = 0; i < n; i++) begin
      r = r * 64'd10;
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_digit_adjust.sv
// Double-dabble correction for one BCD digit: add 3 when the digit is 5 or more,
// so the following left shift carries correctly into the next decade.
module bcd_digit_adjust
  import bin_to_bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] digit,
  output logic [BCD_DIGIT_W-1:0] adjusted
);

  // Pure 4-bit combinational correction; no carry out is possible for valid digits.
  always_comb begin
    adjusted = digit;
    if (digit >= ADD3_THRESHOLD) begin
      adjusted = digit + ADD3_VALUE;
    end
  end

endmodule

// File: rtl/bin_to_bcd.sv
// Sequential double-dabble binary-to-BCD converter, one add-3/shift step per clock.
// Converts on a start pulse or whenever bin_in differs from the value captured at the
// previous conversion start. Results appear on bcd_out/neg only at the done pulse.
// Optional feature: define BIN_TO_BCD_SIGNED_EN to treat bin_in as two's complement
// (magnitude converted, neg set from the sign bit); otherwise neg is always 0.
module bin_to_bcd
  import bin_to_bcd_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DIGITS = 4
) (
  input  logic                          clk,
  input  logic                          rst_btn,
  input  logic [WIDTH-1:0]              bin_in,
  input  logic                          start,
  output logic [BCD_DIGIT_W*DIGITS-1:0] bcd_out,
  output logic                          neg,
  output logic                          busy,
  output logic                          done
);

  localparam int unsigned BcdW = BCD_DIGIT_W * DIGITS;
  localparam int unsigned CntW = $clog2(WIDTH + 1);
  localparam logic [CntW-1:0] LastStep = CntW'(WIDTH - 1);

  // Refuse to build a converter whose output cannot represent the largest input.
  if (pow10(DIGITS) <= ((64'd1 << WIDTH) - 64'd1)) begin : gen_digits_too_few
    $error("bin_to_bcd: DIGITS too small for WIDTH, result would be truncated");
  end

  state_e            state_q;
  logic [WIDTH-1:0]  shift_q;
  logic [BcdW-1:0]   scratch_q;
  logic [BcdW-1:0]   scratch_adj;
  logic [WIDTH-1:0]  last_val_q;
  logic [CntW-1:0]   cnt_q;
  logic              sign_q;
  logic [WIDTH-1:0]  mag;
  logic              sign;
  logic              trigger;

  // Magnitude and sign of the value to capture at conversion start.
  always_comb begin
    mag  = bin_in;
    sign = 1'b0;
`ifdef BIN_TO_BCD_SIGNED_EN
    // The most negative value negates to itself, which read unsigned is its magnitude.
    if (bin_in[WIDTH-1]) begin
      mag  = ~bin_in + WIDTH'(1);
      sign = 1'b1;
    end
`endif
  end

  assign trigger = start || (bin_in != last_val_q);

  for (genvar d = 0; d < DIGITS; d++) begin : gen_adj
    bcd_digit_adjust u_adj (
      .digit    (scratch_q[d*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .adjusted (scratch_adj[d*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  // Control FSM, datapath and registered outputs; scratch never reaches bcd_out mid-run.
  always_ff @(posedge clk or negedge rst_btn) begin
    if (!rst_btn) begin
      state_q    <= StIdle;
      shift_q    <= '0;
      scratch_q  <= '0;
      last_val_q <= '0;
      cnt_q      <= '0;
      sign_q     <= 1'b0;
      bcd_out    <= '0;
      neg        <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (trigger) begin
            shift_q    <= mag;
            sign_q     <= sign;
            last_val_q <= bin_in;
            scratch_q  <= '0;
            cnt_q      <= '0;
            busy       <= 1'b1;
            state_q    <= StShift;
          end
        end
        StShift: begin
          // Adjusted digits shift up one bit, taking the next binary MSB in at the bottom;
          // the top adjusted bit is provably zero, so truncation loses nothing.
          scratch_q <= BcdW'({scratch_adj, shift_q[WIDTH-1]});
          shift_q   <= shift_q << 1;
          cnt_q     <= cnt_q + CntW'(1);
          if (cnt_q == LastStep) begin
            state_q <= StDone;
          end
        end
        StDone: begin
          bcd_out <= scratch_q;
          neg     <= sign_q;
          done    <= 1'b1;
          busy    <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bin_to_bcd.sv
// Directed self-checking bench for bin_to_bcd with a result scoreboard.
// Follows BIN_TO_BCD_SIGNED_EN so expectations match the build under test.
module tb_bin_to_bcd;

  logic        clk = 1'b0;
  logic        rst_btn;
  logic [7:0]  bin_in;
  logic        start;
  logic [15:0] bcd_out;
  logic        neg;
  logic        busy;
  logic        done;

  int          n_assert = 0;
  int          n_fail   = 0;
  int          dones    = 0;
  int          pushed   = 0;
  logic [16:0] exp_q[$];
  logic [16:0] last_result = '0;

  bin_to_bcd #(
    .WIDTH  (8),
    .DIGITS (4)
  ) dut (
    .clk     (clk),
    .rst_btn (rst_btn),
    .bin_in  (bin_in),
    .start   (start),
    .bcd_out (bcd_out),
    .neg     (neg),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  // Reference: {neg, 4 BCD digits} for an 8-bit input.
  function automatic logic [16:0] model(input logic [7:0] v);
    int   mag;
    logic s;
    mag = int'(v);
    s   = 1'b0;
`ifdef BIN_TO_BCD_SIGNED_EN
    if (v[7]) begin
      mag = 256 - int'(v);
      s   = 1'b1;
    end
`endif
    return {s, 4'((mag / 1000) % 10), 4'((mag / 100) % 10), 4'((mag / 10) % 10), 4'(mag % 10)};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      dones++;
      if (exp_q.size() > 0) begin
        logic [16:0] e;
        e = exp_q.pop_front();
        check("result", {15'd0, neg, bcd_out}, {15'd0, e});
        last_result = e;
      end else begin
        check("done_with_empty_scoreboard", 32'(dones), 32'(pushed));
      end
    end
  end

  // Bounded wait for one conversion started on the coming edge; checks timing and hold.
  task automatic wait_done(input string tag, input logic [16:0] prev);
    int k;
    int busy_cycles;
    bit got;
    k = 0;
    busy_cycles = 0;
    got = 1'b0;
    while (!got && k < 40) begin
      @(negedge clk);
      k++;
      start = 1'b0;
      if (done === 1'b1) begin
        got = 1'b1;
      end else begin
        if (busy === 1'b1) busy_cycles++;
        if (k == 5) check({tag, "_hold"}, {15'd0, neg, bcd_out}, {15'd0, prev});
      end
    end
    check({tag, "_got_done"}, 32'(got), 32'd1);
    check({tag, "_latency"}, 32'(k - 1), 32'd9);
    check({tag, "_busy_cycles"}, 32'(busy_cycles), 32'd9);
    check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    @(negedge clk);
    check({tag, "_done_one_cycle"}, 32'(done), 32'd0);
  endtask

  task automatic run_conv(input logic [7:0] v, input bit st, input string tag);
    logic [16:0] prev;
    prev   = last_result;
    bin_in = v;
    start  = st;
    exp_q.push_back(model(v));
    pushed++;
    wait_done(tag, prev);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int  d0;
    bit  busy_seen;
    logic [16:0] e;

    // Reset state, held while the clock runs.
    rst_btn = 1'b0;
    bin_in  = 8'd0;
    start   = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_bcd_out", 32'(bcd_out), 32'h0);
    check("reset_neg", 32'(neg), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    rst_btn = 1'b1;

    // bin_in equal to the reset last value must not trigger anything.
    busy_seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (busy === 1'b1) busy_seen = 1'b1;
    end
    #1;
    check("idle_zero_busy", 32'(busy_seen), 32'd0);
    check("idle_zero_dones", 32'(dones), 32'd0);
    check("idle_zero_bcd", 32'(bcd_out), 32'h0);
    @(negedge clk);

    // Change-triggered conversion of the all-ones input.
    run_conv(8'hFF, 1'b0, "ff");
    e = model(8'hFF);
    check("ff_held_after", {15'd0, neg, bcd_out}, {15'd0, e});

    // Start pulse with unchanged input reconverts.
    repeat (3) @(negedge clk);
    run_conv(8'hFF, 1'b1, "restart");

    // Input change and start while busy are ignored, then the change retriggers once.
    d0     = dones;
    bin_in = 8'd42;
    exp_q.push_back(model(8'd42));
    pushed++;
    repeat (3) @(negedge clk);
    bin_in = 8'd99;
    exp_q.push_back(model(8'd99));
    pushed++;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (40) @(negedge clk);
    #1;
    check("change_two_dones", 32'(dones - d0), 32'd2);
    check("change_queue_empty", 32'(exp_q.size()), 32'd0);
    e = model(8'd99);
    check("change_final", {15'd0, neg, bcd_out}, {15'd0, e});

    // Reset in the middle of a conversion aborts it; the value reconverts after release.
    @(negedge clk);
    bin_in = 8'd200;
    repeat (4) @(negedge clk);
    rst_btn = 1'b0;
    #1;
    check("midreset_bcd_out", 32'(bcd_out), 32'h0);
    check("midreset_neg", 32'(neg), 32'd0);
    check("midreset_busy", 32'(busy), 32'd0);
    check("midreset_done", 32'(done), 32'd0);
    last_result = '0;
    d0 = dones;
    repeat (3) @(negedge clk);
    #1;
    check("midreset_no_done", 32'(dones - d0), 32'd0);
    exp_q.push_back(model(8'd200));
    pushed++;
    rst_btn = 1'b1;
    wait_done("reset_restart", 17'd0);

    // Boundary values: most negative / 128, single digit, exact hundred, zero.
    run_conv(8'h80, 1'b0, "v80");
    run_conv(8'd9, 1'b0, "v9");
    run_conv(8'd100, 1'b0, "v100");
    run_conv(8'd0, 1'b0, "v0");

    repeat (15) @(negedge clk);
    #1;
    check("total_dones", 32'(dones), 32'(pushed));
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/bin_to_bcd.md
BIN_TO_BCD -- requirements
Module: bin_to_bcd

Interface
REQ-001 Parameter WIDTH, default 8: binary input width.
REQ-002 Parameter DIGITS, default 4: number of BCD output digits.
REQ-003 Port clk  input  1: single clock; all state updates on its rising edge.
REQ-004 Port rst_btn  input  1: asynchronous, active-low reset.
REQ-005 Port bin_in  input  WIDTH: binary value to convert; driven by the CPU output register.
REQ-006 Port start  input  1: one-cycle request to convert bin_in unconditionally.
REQ-007 Port bcd_out  output  4*DIGITS: packed BCD result; digit 0 in bits [3:0]; feeds the 4-digit display number.
REQ-008 Port neg  output  1: result sign flag, registered together with bcd_out.
REQ-009 Port busy  output  1: high while a conversion is in progress.
REQ-010 Port done  output  1: one-cycle pulse on the cycle bcd_out updates.

Function
REQ-011 Algorithm SHALL be sequential double-dabble: one add-3-then-shift step per clock, WIDTH steps per conversion.
REQ-012 FSM states SHALL be IDLE, SHIFT, DONE.
REQ-013 Trigger in IDLE: start==1 or bin_in != last_val (last_val = bin_in captured at the previous conversion start).
REQ-014 On the trigger edge T0: capture bin_in into the shift register and into last_val, clear the BCD scratch, clear the step count, enter SHIFT, set busy=1.
REQ-015 SHIFT: each edge adds 3 to every scratch digit >=5, then shifts left by one; after WIDTH steps enter DONE.
REQ-016 DONE edge (T0+WIDTH+1): load bcd_out and neg, pulse done=1 for exactly one cycle, set busy=0, return to IDLE.
REQ-017 bcd_out and neg SHALL hold their value between conversions; no intermediate scratch values are visible.
REQ-018 start or bin_in changes while busy SHALL be ignored, not queued; a bin_in that differs from last_val retriggers on the first IDLE cycle after DONE.
REQ-019 Back-to-back conversions SHALL be possible: IDLE-to-IDLE turnaround is exactly one IDLE cycle.
REQ-020 Elaboration SHALL fail when 10^DIGITS <= 2^WIDTH-1, so digits are never truncated.

Reset
REQ-021 While rst_btn==0, the block SHALL force bcd_out=0, neg=0, busy=0, done=0, last_val=0, step count=0 and state IDLE, independent of clk.
REQ-022 Reset mid-conversion SHALL abort it with no done pulse; after release, bin_in!=0 triggers a new conversion.

Configuration
REQ-023 Macro BIN_TO_BCD_SIGNED_EN defined: bin_in is two's complement; the magnitude is converted and neg=MSB of the captured value; the most negative value converts to its full magnitude (8'h80 -> 128, neg=1).
REQ-024 Macro BIN_TO_BCD_SIGNED_EN undefined: bin_in is unsigned and neg is tied to 0; the port list is unchanged.

Structure
REQ-025 Package bin_to_bcd_pkg SHALL hold the FSM state encodings, the BCD_DIGIT_W=4 constant and the add-3 threshold constant.
REQ-026 The per-digit correction (>=5 then +3, 4-bit combinational) SHALL be the sub-module bcd_digit_adjust, instantiated DIGITS times.

Verification
REQ-027 Reset, then bin_in=0 held for 20 cycles -> no done, busy=0, bcd_out=16'h0000.
REQ-028 bin_in=8'd255 after reset -> busy for 9 cycles, done at T0+9, bcd_out=16'h0255, neg=0.
REQ-029 After REQ-028 settles, start pulse with bin_in unchanged -> reconversion, done at T0+9, bcd_out=16'h0255.
REQ-030 bin_in=42, then changed to 99 at T0+3 -> first done gives 16'h0042; second conversion starts automatically and gives 16'h0099; exactly two done pulses.
REQ-031 Reset asserted at T0+4 of a conversion -> outputs zero immediately, no done pulse; conversion restarts after release.
REQ-032 bin_in=8'hFF: with BIN_TO_BCD_SIGNED_EN -> 16'h0001, neg=1; without it -> 16'h0255, neg=0; with it, 8'h80 -> 16'h0128, neg=1.
